bitty_fetch: RTL and testbench

BITTY_FETCH -- requirements
Module: bitty_fetch

---
 rtl/bitty_pkg.sv | 23 ++
 rtl/bitty_watchdog.sv | 34 +++
 rtl/bitty_fetch.sv | 169 ++++++++++++++++
 tb/tb_bitty_fetch.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty instruction fetch unit.
package bitty_pkg;

    localparam int unsigned InstrW = 16;

    // Reserved opcode that stops the program instead of being issued.
    localparam logic [InstrW-1:0] HaltOpcode = 16'hFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StMemWait,
        StIssue,
        StExec,
        StHalted
    } state_e;

    // The unit counts as busy whenever a program is in flight.
    function automatic logic is_busy(input state_e s);
        return (s != StIdle) && (s != StHalted);
    endfunction

endpackage

// File: rtl/bitty_watchdog.sv
// Saturating wait counter that flags when the programmed limit is reached.
module bitty_watchdog #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limit,
    output logic         o_expired
);

    logic [W-1:0] r_count;
    logic [W:0]   w_count_inc;

    // Count enabled cycles since the last clear, holding at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expired means the current waiting cycle is the limit-th one since the clear.
    // Kept independent of i_enable so the caller can gate on it without a loop.
    always_comb begin
        w_count_inc = {1'b0, r_count} + {{W{1'b0}}, 1'b1};
        o_expired   = w_count_inc >= {1'b0, i_limit};
    end

endmodule

// File: rtl/bitty_fetch.sv
// Instruction fetch/issue sequencer for the bitty core.
module bitty_fetch
    import bitty_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned LAST_ADDR = 2 ** ADDR_W - 1,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [InstrW-1:0] mem_rdata,
    output logic [InstrW-1:0] d_instr,
    output logic              run,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err,
    output logic [15:0]       icount
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(LAST_ADDR);
    // The run cycle is the first cycle of the timeout window, so EXEC itself
    // only waits TIMEOUT-1 cycles before giving up.
    localparam logic [CntW-1:0] WdLimit = CntW'(TIMEOUT - 1);

    state_e              r_state, w_state;
    logic                r_mem_en, w_mem_en;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
    logic [InstrW-1:0]   r_d_instr, w_d_instr;
    logic                r_run, w_run;
    logic [ADDR_W-1:0]   r_pc, w_pc;
    logic                r_busy, w_busy;
    logic                r_halted, w_halted;
    logic                r_timeout_err, w_timeout_err;
    logic [15:0]         r_icount, w_icount;
    logic                w_wd_clear, w_wd_en, w_wd_expired;

    bitty_watchdog #(
        .W (CntW)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_en),
        .i_limit   (WdLimit),
        .o_expired (w_wd_expired)
    );

    // State and every output are registered; reset forces IDLE at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_mem_en      <= 1'b0;
            r_mem_addr    <= '0;
            r_d_instr     <= '0;
            r_run         <= 1'b0;
            r_pc          <= '0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_icount      <= '0;
        end else begin
            r_state       <= w_state;
            r_mem_en      <= w_mem_en;
            r_mem_addr    <= w_mem_addr;
            r_d_instr     <= w_d_instr;
            r_run         <= w_run;
            r_pc          <= w_pc;
            r_busy        <= w_busy;
            r_halted      <= w_halted;
            r_timeout_err <= w_timeout_err;
            r_icount      <= w_icount;
        end
    end

    // Next-state logic; outputs are computed for the state being entered.
    always_comb begin
        w_state       = r_state;
        w_mem_en      = 1'b0;
        w_mem_addr    = r_mem_addr;
        w_d_instr     = r_d_instr;
        w_run         = 1'b0;
        w_pc          = r_pc;
        w_halted      = r_halted;
        w_timeout_err = r_timeout_err;
        w_icount      = r_icount;
        w_wd_clear    = 1'b0;
        w_wd_en       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state       = StFetch;
                    w_pc          = '0;
                    w_icount      = '0;
                    w_timeout_err = 1'b0;
                    w_mem_en      = 1'b1;
                    w_mem_addr    = '0;
                end
            end
            StFetch: begin
                w_state = StMemWait;
            end
            StMemWait: begin
                w_d_instr = mem_rdata;
                if (mem_rdata == HaltOpcode) begin
                    w_state  = StHalted;
                    w_halted = 1'b1;
                end else begin
                    w_state = StIssue;
                    w_run   = 1'b1;
                end
            end
            StIssue: begin
                w_wd_clear = 1'b1;
                w_state    = StExec;
            end
            StExec: begin
                if (done) begin
                    w_icount = (r_icount == 16'hFFFF) ? r_icount : r_icount + 16'd1;
                    if (r_pc == LastPc) begin
                        w_state  = StHalted;
                        w_halted = 1'b1;
                    end else begin
                        w_pc       = r_pc + 1'b1;
                        w_mem_addr = r_pc + 1'b1;
                        w_mem_en   = 1'b1;
                        w_state    = StFetch;
                    end
                end else begin
                    w_wd_en = 1'b1;
                    if (w_wd_expired) begin
                        w_timeout_err = 1'b1;
                        w_state       = StHalted;
                        w_halted      = 1'b1;
                    end
                end
            end
            StHalted: begin
                // Holding start high must not restart; a low level re-arms.
                if (!start) begin
                    w_state  = StIdle;
                    w_halted = 1'b0;
                end
            end
            default: begin
                w_state = StIdle;
            end
        endcase

        w_busy = is_busy(w_state);
    end

    assign mem_en      = r_mem_en;
    assign mem_addr    = r_mem_addr;
    assign d_instr     = r_d_instr;
    assign run         = r_run;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign timeout_err = r_timeout_err;
    assign icount      = r_icount;

endmodule

// File: tb/tb_bitty_fetch.sv
// Self-checking bench for bitty_fetch with a cycle-level program model.
module tb_bitty_fetch;

    localparam int unsigned AddrW    = 8;
    localparam int unsigned LastAddr = 3;
    localparam int unsigned Timeout  = 8;
    localparam int          Budget   = 150;

    logic             clk;
    logic             reset;
    logic             start;
    logic             mem_en;
    logic [AddrW-1:0] mem_addr;
    logic [15:0]      mem_rdata;
    logic [15:0]      d_instr;
    logic             run;
    logic             done;
    logic [AddrW-1:0] pc;
    logic             busy;
    logic             halted;
    logic             timeout_err;
    logic [15:0]      icount;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:255];
    int          dly [0:3];

    int          exp_nrun;
    int          exp_t [0:7];
    logic [15:0] exp_i [0:7];
    int          exp_halt_t;
    int          exp_pc;
    int          exp_icount;
    logic        exp_to;

    bitty_fetch #(
        .ADDR_W    (AddrW),
        .LAST_ADDR (LastAddr),
        .TIMEOUT   (Timeout)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .d_instr     (d_instr),
        .run         (run),
        .done        (done),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .timeout_err (timeout_err),
        .icount      (icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data valid the cycle after mem_en, garbage otherwise.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 16'($urandom);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timed out");
    end

    // Expected behaviour from the program rules. Cycle 0 is the cycle start is
    // first presented while idle; runs land 3 cycles after start or after done.
    task automatic model_program();
        int t;
        int p;
        t = 3;
        p = 0;
        exp_nrun = 0;
        exp_icount = 0;
        exp_to = 1'b0;
        exp_halt_t = -1;
        for (int k = 0; k <= int'(LastAddr); k++) begin
            p = k;
            if (mem[k] == 16'hFFFF) begin
                exp_halt_t = t;
                break;
            end
            exp_t[exp_nrun] = t;
            exp_i[exp_nrun] = mem[k];
            exp_nrun++;
            if (dly[k] >= int'(Timeout)) begin
                exp_to = 1'b1;
                exp_halt_t = t + int'(Timeout);
                break;
            end
            exp_icount++;
            if (k == int'(LastAddr)) begin
                exp_halt_t = t + dly[k] + 1;
                break;
            end
            t = t + dly[k] + 3;
        end
        exp_pc = p;
    endtask

    // Run one program with start held through the halt, acting as the core.
    task automatic run_and_check(input string name, input logic done_on_run);
        int          nrun;
        int          halt_t;
        int          done_at;
        int          got_t [0:7];
        logic [15:0] got_i [0:7];
        logic        overlap;
        logic        addr_bad;
        model_program();
        nrun = 0;
        halt_t = -1;
        done_at = -1;
        overlap = 1'b0;
        addr_bad = 1'b0;
        @(negedge clk);
        start = 1'b1;
        done = 1'b0;
        for (int cyc = 1; cyc <= Budget; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checks++;
                if ({mem_en, busy, pc, icount} !== {1'b1, 1'b1, 8'd0, 16'd0}) begin
                    failures++;
                    $display("FAIL %s_first_fetch: got en=%0b busy=%0b pc=%0d icount=%0d expected 1 1 0 0",
                             name, mem_en, busy, pc, icount);
                end
            end
            if (mem_en && run) overlap = 1'b1;
            if (mem_en && (mem_addr !== 8'(nrun))) addr_bad = 1'b1;
            if (run) begin
                if (nrun < 8) begin
                    got_t[nrun] = cyc;
                    got_i[nrun] = d_instr;
                end
                if (nrun < 4) done_at = cyc + dly[nrun];
                nrun++;
            end
            if (halted && halt_t < 0) halt_t = cyc;
            done = (cyc == done_at) || (done_on_run && run);
            if (halt_t >= 0 && cyc >= halt_t + 4) break;
        end
        done = 1'b0;

        checks++;
        if (halt_t !== exp_halt_t) begin
            failures++;
            $display("FAIL %s_halt_cycle: got %0d expected %0d", name, halt_t, exp_halt_t);
        end
        checks++;
        if (nrun !== exp_nrun) begin
            failures++;
            $display("FAIL %s_run_count: got %0d expected %0d", name, nrun, exp_nrun);
        end
        for (int k = 0; k < exp_nrun && k < nrun && k < 8; k++) begin
            checks++;
            if (got_t[k] !== exp_t[k] || got_i[k] !== exp_i[k]) begin
                failures++;
                $display("FAIL %s_run%0d: got cycle %0d instr %h expected cycle %0d instr %h",
                         name, k, got_t[k], got_i[k], exp_t[k], exp_i[k]);
            end
        end
        checks++;
        if (pc !== 8'(exp_pc)) begin
            failures++;
            $display("FAIL %s_pc: got %0d expected %0d", name, pc, exp_pc);
        end
        checks++;
        if (icount !== 16'(exp_icount)) begin
            failures++;
            $display("FAIL %s_icount: got %0d expected %0d", name, icount, exp_icount);
        end
        checks++;
        if (timeout_err !== exp_to) begin
            failures++;
            $display("FAIL %s_timeout_err: got %0b expected %0b", name, timeout_err, exp_to);
        end
        checks++;
        if ({halted, busy} !== 2'b10) begin
            failures++;
            $display("FAIL %s_held_halted: got halted=%0b busy=%0b expected 1 0", name, halted, busy);
        end
        checks++;
        if ({overlap, addr_bad} !== 2'b00) begin
            failures++;
            $display("FAIL %s_fetch_bus: got overlap=%0b bad_addr=%0b expected 0 0",
                     name, overlap, addr_bad);
        end

        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({halted, busy, mem_en} !== 3'b000) begin
            failures++;
            $display("FAIL %s_return_idle: got halted=%0b busy=%0b en=%0b expected 0 0 0",
                     name, halted, busy, mem_en);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_en, run, busy, halted, timeout_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got en=%0b run=%0b busy=%0b halted=%0b to=%0b expected 0",
                     mem_en, run, busy, halted, timeout_err);
        end
        checks++;
        if ({mem_addr, pc, d_instr, icount} !== 48'd0) begin
            failures++;
            $display("FAIL reset_values: got addr=%0d pc=%0d instr=%h icount=%0d expected 0",
                     mem_addr, pc, d_instr, icount);
        end
        reset = 1'b0;
        begin
            logic moved;
            moved = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (busy || mem_en || run) moved = 1'b1;
            end
            checks++;
            if (moved !== 1'b0) begin
                failures++;
                $display("FAIL reset_needs_start: got moved=%0b expected 0", moved);
            end
        end
    endtask

    task automatic test_idle_done();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, mem_en, run, icount} !== 19'd0) begin
            failures++;
            $display("FAIL idle_done_ignored: got busy=%0b en=%0b run=%0b icount=%0d expected 0",
                     busy, mem_en, run, icount);
        end
    endtask

    task automatic test_halt_opcode();
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        mem[2] = 16'hFFFF;
        mem[3] = 16'h0BAD;
        for (int k = 0; k < 4; k++) dly[k] = 2;
        run_and_check("halt_opcode", 1'b1);
    endtask

    task automatic test_last_addr();
        for (int k = 0; k < 4; k++) begin
            mem[k] = 16'(k + 1);
            dly[k] = 2 + k;
        end
        run_and_check("last_addr", 1'b0);
    endtask

    task automatic test_timeout();
        mem[0] = 16'hABCD;
        mem[1] = 16'h0001;
        mem[2] = 16'h0002;
        mem[3] = 16'h0003;
        dly[0] = 100;
        for (int k = 1; k < 4; k++) dly[k] = 1;
        run_and_check("timeout", 1'b1);
    endtask

    task automatic test_reset_mid_exec();
        int   nr;
        logic pend;
        for (int k = 0; k < 4; k++) begin
            mem[k] = 16'h1111 * 16'(k + 1);
            dly[k] = 3;
        end
        nr = 0;
        pend = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 60 && nr < 2; c++) begin
            @(negedge clk);
            done = pend;
            pend = 1'b0;
            if (run) begin
                nr++;
                if (nr == 1) pend = 1'b1;
            end
        end
        @(negedge clk);
        done = 1'b0;
        checks++;
        if ({8'(nr), pc, busy} !== {8'd2, 8'd1, 1'b1}) begin
            failures++;
            $display("FAIL mid_exec_reach: got runs=%0d pc=%0d busy=%0b expected 2 1 1", nr, pc, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, run, pc, halted, mem_en} !== 12'd0) begin
            failures++;
            $display("FAIL mid_exec_async_reset: got busy=%0b run=%0b pc=%0d halted=%0b expected 0",
                     busy, run, pc, halted);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        run_and_check("after_reset", 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    mem[k] = 16'hFFFF;
                end else begin
                    mem[k] = 16'($urandom_range(0, 16'hFFFE));
                end
                dly[k] = $urandom_range(1, 9);
            end
            run_and_check($sformatf("random%0d", it), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        for (int k = 0; k < 4; k++) dly[k] = 1;
        reset = 1'b1;
        start = 1'b0;
        done = 1'b0;
        test_reset();
        test_idle_done();
        test_halt_opcode();
        test_last_addr();
        test_timeout();
        test_reset_mid_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
